// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, next-PC select codes and the
// select decode used when an instruction resolves.
//
// Contents:
//   state_e        FSM state type
//   PcSel*         next-PC source codes driven on pc_sel
//   pc_sel_decode  branch/jump/zero -> next-PC source
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StFetch,
        StDecode,
        StExec,
        StUpdate,
        StHalt,
        StFault
    } state_e;

    localparam logic [1:0] PcSelSeq = 2'b00;  // pc + 4
    localparam logic [1:0] PcSelBr  = 2'b01;  // pc + offset
    localparam logic [1:0] PcSelJ   = 2'b10;  // j_address
    localparam logic [1:0] PcSelJr  = 2'b11;  // reg_read_out1

    // Branch and Jump together encode a register jump; it wins regardless of Zero.
    function automatic logic [1:0] pc_sel_decode(input logic branch, input logic jump,
                                                 input logic zero);
        logic [1:0] sel;
        if (branch && jump) begin
            sel = PcSelJr;
        end else if (jump) begin
            sel = PcSelJ;
        end else if (branch && zero) begin
            sel = PcSelBr;
        end else begin
            sel = PcSelSeq;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for instruction memory and flags expiry on the
// Timeout-th consecutive enabled cycle.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-low reset
//   clear   in   return count to zero (has priority over enable)
//   enable  in   count this cycle
//   expire  out  this is the Timeout-th enabled cycle since the last clear
module pc_sequencer_fetch_watchdog #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned TmrW = $clog2(Timeout + 1);
    localparam logic [TmrW-1:0] LastCount = TmrW'(Timeout - 1);

    logic [TmrW-1:0] count_q, count_d;

    // Count value k means k full cycles have already elapsed, so the last cycle is Timeout-1.
    assign expire = enable && (count_q == LastCount);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer. Steps each instruction through FETCH, DECODE, EXEC and
// UPDATE, requests instruction memory, and is the only source of the PC load/write/select
// controls. Supports halting at an instruction boundary, resume, and a sticky fetch-timeout fault.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   start         in   cold start from IDLE, resume from HALT
//   halt_req      in   stop at the next instruction boundary
//   imem_ack      in   instruction memory data valid
//   ex_done       in   execute result and Zero valid
//   Branch        in   decoded conditional branch
//   Jump          in   decoded jump (with Branch: register jump)
//   Zero          in   ALU zero flag
//   pc_load_init  out  PC loads its initial value
//   pc_write      out  PC updates from the pc_sel source
//   pc_sel        out  next-PC source, held between updates
//   imem_req      out  fetch request
//   ir_write      out  latch the instruction register
//   busy          out  executing (not IDLE/HALT/FAULT)
//   halted        out  in HALT
//   fault         out  fetch timeout, sticky until reset
//   retired_cnt   out  saturating count of completed instructions
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             imem_ack,
    input  logic             ex_done,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    output logic             pc_load_init,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             imem_req,
    output logic             ir_write,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e           state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic             br_q, br_d;
    logic             j_q, j_d;
    logic [1:0]       pc_sel_q, pc_sel_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic in_fetch;
    logic wd_expire;

    assign in_fetch = (state_q == StFetch);

    pc_sequencer_fetch_watchdog #(
        .Timeout (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_fetch),
        .enable (in_fetch),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        br_d        = br_q;
        j_d         = j_q;
        pc_sel_d    = pc_sel_q;
        retired_d   = retired_q;

        if (busy && halt_req) begin
            halt_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                state_d = StFetch;
            end
            StFetch: begin
                // An ack arriving on the expiry cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = StDecode;
                end else if (wd_expire) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                br_d    = Branch;
                j_d     = Jump;
                state_d = StExec;
            end
            StExec: begin
                // Select is resolved here so pc_sel is a plain register during UPDATE.
                if (ex_done) begin
                    pc_sel_d = pc_sel_decode(br_q, j_q, Zero);
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + 1'b1;
                end
                // A request arriving during UPDATE is already at the boundary.
                if (halt_pend_q || halt_req) begin
                    halt_pend_d = 1'b0;
                    state_d     = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            halt_pend_q <= 1'b0;
            br_q        <= 1'b0;
            j_q         <= 1'b0;
            pc_sel_q    <= PcSelSeq;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            br_q        <= br_d;
            j_q         <= j_d;
            pc_sel_q    <= pc_sel_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        pc_load_init = (state_q == StInit);
        pc_write     = (state_q == StUpdate);
        pc_sel       = pc_sel_q;
        imem_req     = in_fetch;
        ir_write     = in_fetch && imem_ack;
        halted       = (state_q == StHalt);
        fault        = (state_q == StFault);
        busy         = (state_q != StIdle) && (state_q != StHalt) && (state_q != StFault);
        retired_cnt  = retired_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int TO = 15;

    // Model phases named after the behavioural description.
    localparam int P_IDLE   = 0;
    localparam int P_INIT   = 1;
    localparam int P_FETCH  = 2;
    localparam int P_DECODE = 3;
    localparam int P_EXEC   = 4;
    localparam int P_UPDATE = 5;
    localparam int P_HALT   = 6;
    localparam int P_FAULT  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, ex_done = 1'b0;
    logic Branch = 1'b0, Jump = 1'b0, Zero = 1'b0;

    logic        pc_load_init, pc_write, imem_req, ir_write, busy, halted, fault;
    logic [1:0]  pc_sel;
    logic [15:0] retired_cnt;

    logic        pc_load_init2, pc_write2, imem_req2, ir_write2, busy2, halted2, fault2;
    logic [1:0]  pc_sel2;
    logic [1:0]  retired_cnt2;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.CNT_W(16), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .imem_ack(imem_ack),
        .ex_done(ex_done), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .pc_load_init(pc_load_init), .pc_write(pc_write), .pc_sel(pc_sel),
        .imem_req(imem_req), .ir_write(ir_write), .busy(busy), .halted(halted),
        .fault(fault), .retired_cnt(retired_cnt)
    );

    pc_sequencer #(.CNT_W(2), .FETCH_TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .imem_ack(imem_ack),
        .ex_done(ex_done), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .pc_load_init(pc_load_init2), .pc_write(pc_write2), .pc_sel(pc_sel2),
        .imem_req(imem_req2), .ir_write(ir_write2), .busy(busy2), .halted(halted2),
        .fault(fault2), .retired_cnt(retired_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_ph = P_IDLE;
    int         m_wait = 0;     // fetch cycles already spent without ack
    int         m_retired = 0;  // unbounded count; saturation applied when comparing
    bit         m_hp = 1'b0, m_br = 1'b0, m_j = 1'b0;
    logic [1:0] m_sel = 2'b00;

    function automatic bit m_busy(input int ph);
        return ph == P_INIT || ph == P_FETCH || ph == P_DECODE || ph == P_EXEC || ph == P_UPDATE;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= P_IDLE; m_wait <= 0; m_retired <= 0;
            m_hp <= 1'b0; m_br <= 1'b0; m_j <= 1'b0; m_sel <= 2'b00;
        end else begin
            if (m_busy(m_ph) && halt_req && m_ph != P_UPDATE) m_hp <= 1'b1;
            case (m_ph)
                P_IDLE:   if (start) m_ph <= P_INIT;
                P_INIT:   begin m_ph <= P_FETCH; m_wait <= 0; end
                P_FETCH: begin
                    if (imem_ack) m_ph <= P_DECODE;
                    else if (m_wait + 1 == TO) m_ph <= P_FAULT;
                    else m_wait <= m_wait + 1;
                end
                P_DECODE: begin m_br <= Branch; m_j <= Jump; m_ph <= P_EXEC; end
                P_EXEC: begin
                    if (ex_done) begin
                        m_ph <= P_UPDATE;
                        if (m_br && m_j) m_sel <= 2'd3;
                        else if (m_j) m_sel <= 2'd2;
                        else if (m_br && Zero) m_sel <= 2'd1;
                        else m_sel <= 2'd0;
                    end
                end
                P_UPDATE: begin
                    m_retired <= m_retired + 1;
                    if (m_hp || halt_req) begin m_ph <= P_HALT; m_hp <= 1'b0; end
                    else begin m_ph <= P_FETCH; m_wait <= 0; end
                end
                P_HALT:   if (start) begin m_ph <= P_FETCH; m_wait <= 0; end
                default:  m_ph <= P_FAULT;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc_load_init", {31'd0, pc_load_init}, {31'd0, m_ph == P_INIT});
            chk("pc_write", {31'd0, pc_write}, {31'd0, m_ph == P_UPDATE});
            chk("pc_sel", {30'd0, pc_sel}, {30'd0, m_sel});
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_ph == P_FETCH});
            chk("ir_write", {31'd0, ir_write}, {31'd0, m_ph == P_FETCH && imem_ack});
            chk("busy", {31'd0, busy}, {31'd0, m_busy(m_ph)});
            chk("halted", {31'd0, halted}, {31'd0, m_ph == P_HALT});
            chk("fault", {31'd0, fault}, {31'd0, m_ph == P_FAULT});
            chk("retired_cnt", {16'd0, retired_cnt}, (m_retired > 65535) ? 65535 : m_retired);
            chk("pc_write_w2", {31'd0, pc_write2}, {31'd0, m_ph == P_UPDATE});
            chk("pc_sel_w2", {30'd0, pc_sel2}, {30'd0, m_sel});
            chk("busy_w2", {31'd0, busy2}, {31'd0, m_busy(m_ph)});
            chk("retired_cnt_w2", {30'd0, retired_cnt2}, (m_retired > 3) ? 3 : m_retired);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Entered while in FETCH with ack/ex_done high; leaves in FETCH of the next instruction.
    task automatic instr(input logic br, input logic j, input logic z, input logic [1:0] exp);
        Branch = br; Jump = j; Zero = z;
        cyc(); cyc(); cyc();
        chk("instr_pc_write", {31'd0, pc_write}, 32'd1);
        chk("instr_pc_sel", {30'd0, pc_sel}, {30'd0, exp});
        cyc();
    endtask

    logic [11:0] pw;

    initial begin
        #1 rst = 1'b0;
        chk_on = 1'b1;
        #20;
        chk("reset_outputs", {pc_load_init, pc_write, pc_sel, imem_req, ir_write, busy, halted,
                              fault}, 32'd0);
        chk("reset_retired", {16'd0, retired_cnt}, 32'd0);
        rst = 1'b1;
        cyc();

        // halt_req is ignored in IDLE
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        chk("idle_ignores_halt", {30'd0, busy, halted}, 32'd0);

        // cold start, immediate acks: one instruction every 4 cycles
        start = 1'b1; imem_ack = 1'b1; ex_done = 1'b1;
        cyc();
        chk("init_pc_load", {31'd0, pc_load_init}, 32'd1);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pw[i] = pc_write;
        end
        chk("pc_write_every_4th", {20'd0, pw}, 32'h888);
        cyc();
        chk("retired_after_3", {16'd0, retired_cnt}, 32'd3);
        chk("seq_pc_sel", {30'd0, pc_sel}, 32'd0);

        // next-PC select decode
        instr(1'b1, 1'b0, 1'b1, 2'b01);
        instr(1'b1, 1'b0, 1'b0, 2'b00);
        instr(1'b0, 1'b1, 1'b0, 2'b10);
        instr(1'b1, 1'b1, 1'b0, 2'b11);
        instr(1'b1, 1'b1, 1'b1, 2'b11);
        instr(1'b0, 1'b1, 1'b1, 2'b10);

        // halt request during EXEC completes the instruction first
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        cyc(); cyc();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        chk("halt_update_completes", {31'd0, pc_write}, 32'd1);
        cyc();
        chk("halted", {30'd0, halted, busy}, 32'b10);
        chk("retired_at_halt", {16'd0, retired_cnt}, 32'd10);
        cyc();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        cyc();
        chk("still_halted", {31'd0, halted}, 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_fetch", {29'd0, imem_req, pc_load_init, halted}, 32'b100);
        instr(1'b0, 1'b0, 1'b0, 2'b00);
        chk("no_rehalt", {31'd0, halted}, 32'd0);

        // ack on the last allowed fetch cycle still decodes
        imem_ack = 1'b0;
        repeat (14) cyc();
        chk("fetch_cycle_15", {30'd0, imem_req, fault}, 32'b10);
        imem_ack = 1'b1;
        #1;
        chk("late_ack_ir_write", {31'd0, ir_write}, 32'd1);
        cyc();
        chk("late_ack_decode", {29'd0, imem_req, fault, busy}, 32'b001);
        cyc(); cyc(); cyc();
        chk("retired_12", {16'd0, retired_cnt}, 32'd12);

        // asynchronous reset while stuck in EXEC
        ex_done = 1'b0;
        cyc(); cyc(); cyc();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {pc_load_init, pc_write, pc_sel, imem_req, ir_write, busy,
                                  halted, fault}, 32'd0);
        chk("async_rst_retired", {14'd0, retired_cnt, retired_cnt2}, 32'd0);
        #10 rst = 1'b1;
        cyc();
        start = 1'b1; ex_done = 1'b1; imem_ack = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        instr(1'b0, 1'b0, 1'b0, 2'b00);
        instr(1'b1, 1'b0, 1'b1, 2'b01);
        instr(1'b0, 1'b1, 1'b0, 2'b10);
        instr(1'b1, 1'b1, 1'b0, 2'b11);
        instr(1'b0, 1'b0, 1'b1, 2'b00);
        chk("retired_5", {16'd0, retired_cnt}, 32'd5);
        chk("retired_sat_w2", {30'd0, retired_cnt2}, 32'd3);

        // fetch timeout
        imem_ack = 1'b0;
        repeat (15) cyc();
        chk("fault_entered", {28'd0, fault, busy, pc_write, imem_req}, 32'b1000);
        cyc(); cyc();
        imem_ack = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("fault_cleared_by_rst", {31'd0, fault}, 32'd0);
        chk_on = 1'b0;
        #10;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
